// File: rtl/pong_btn_if.sv
// pong_btn_if: groups the raw button levels and the conditioned command
// outputs of pong_btn_ctrl.
//   btn_*       raw asynchronous push-button levels (active-high)
//   mv_*        single-cycle paddle step pulses
//   start_pulse single-cycle pulse on an accepted start press
//   btn_lvl     debounced levels {start, dn_b, up_b, dn_a, up_a}
// master: the side that owns the buttons and consumes the pulses.
// slave : the conditioner itself.
interface pong_btn_if;
    logic       btn_up_a;
    logic       btn_dn_a;
    logic       btn_up_b;
    logic       btn_dn_b;
    logic       btn_start;
    logic       mv_up_a;
    logic       mv_dn_a;
    logic       mv_up_b;
    logic       mv_dn_b;
    logic       start_pulse;
    logic [4:0] btn_lvl;

    modport master (
        output btn_up_a, btn_dn_a, btn_up_b, btn_dn_b, btn_start,
        input  mv_up_a, mv_dn_a, mv_up_b, mv_dn_b, start_pulse, btn_lvl
    );

    modport slave (
        input  btn_up_a, btn_dn_a, btn_up_b, btn_dn_b, btn_start,
        output mv_up_a, mv_dn_a, mv_up_b, mv_dn_b, start_pulse, btn_lvl
    );
endinterface

// File: rtl/pong_btn_ctrl.sv
// pong_btn_ctrl: button conditioner in front of the pong game FSM.
// Each of the five raw buttons is synchronised (2 flops) and debounced
// (needs DEBOUNCE_CYC consecutive differing samples to flip). The debounced
// levels are registered onto btn_lvl, and that registered vector drives:
//   - one IDLE/UP/DN FSM per paddle, producing a step pulse on entry and
//     then one every REPEAT_CYC cycles while the direction is held alone;
//   - a rising-edge detector for start (one pulse per press).
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, clears all state and outputs
//   bus  pong_btn_if.slave (raw buttons in, pulses and btn_lvl out)
// Raw rise sampled at edge 0 -> btn_lvl at edge 6 -> first pulse at edge 7
// (for DEBOUNCE_CYC = 4).
module pong_btn_ctrl #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_CYC   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    pong_btn_if.slave  bus
);
    localparam int NBTN = 5;
    localparam int NPAD = 2;
    localparam int DW   = $clog2(DEBOUNCE_CYC);
    localparam int RW   = $clog2(REPEAT_CYC);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {IDLE, UP, DN} pad_state_e;

    // bit order everywhere: {start, dn_b, up_b, dn_a, up_a}
    logic [NBTN-1:0]          raw;
    logic [NBTN-1:0]          sync1_q, sync2_q;
    logic [NBTN-1:0]          stable_q, stable_d;
    logic [NBTN-1:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [NBTN-1:0]          lvl_q;
    logic                     start_prev_q;
    logic                     start_q, start_d;
    logic [NPAD-1:0]          mv_up_q, mv_up_d;
    logic [NPAD-1:0]          mv_dn_q, mv_dn_d;

    assign raw = {bus.btn_start, bus.btn_dn_b, bus.btn_up_b, bus.btn_dn_a, bus.btn_up_a};

    // Debounce: count consecutive cycles where sync disagrees with stable;
    // the edge on which the count already sits at DB_LAST commits the flip.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NBTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Paddle FSMs work off the registered debounced levels.
    for (genvar p = 0; p < NPAD; p++) begin : g_pad
        pad_state_e    state_q, state_d;
        logic [RW-1:0] rep_q, rep_d;
        logic          up_lvl, dn_lvl;
        logic          up_step, dn_step;

        assign up_lvl = lvl_q[2*p];
        assign dn_lvl = lvl_q[2*p+1];

        always_comb begin
            state_d = state_q;
            rep_d   = rep_q;
            up_step = 1'b0;
            dn_step = 1'b0;
            case (state_q)
                IDLE: begin
                    // both or neither held: stay put
                    if (up_lvl && !dn_lvl) begin
                        state_d = UP;
                        up_step = 1'b1;
                        rep_d   = '0;
                    end else if (dn_lvl && !up_lvl) begin
                        state_d = DN;
                        dn_step = 1'b1;
                        rep_d   = '0;
                    end
                end
                UP: begin
                    if (up_lvl && !dn_lvl) begin
                        if (rep_q == REP_LAST) begin
                            up_step = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        // drop out silently; IDLE re-decides next cycle
                        state_d = IDLE;
                        rep_d   = '0;
                    end
                end
                DN: begin
                    if (dn_lvl && !up_lvl) begin
                        if (rep_q == REP_LAST) begin
                            dn_step = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        rep_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rep_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                rep_q   <= '0;
            end else begin
                state_q <= state_d;
                rep_q   <= rep_d;
            end
        end

        assign mv_up_d[p] = up_step;
        assign mv_dn_d[p] = dn_step;
    end

    // start: rising edge of the registered debounced level
    always_comb begin
        start_d = lvl_q[4] & ~start_prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            db_cnt_q     <= '0;
            lvl_q        <= '0;
            start_prev_q <= 1'b0;
            start_q      <= 1'b0;
            mv_up_q      <= '0;
            mv_dn_q      <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            db_cnt_q     <= db_cnt_d;
            lvl_q        <= stable_q;
            start_prev_q <= lvl_q[4];
            start_q      <= start_d;
            mv_up_q      <= mv_up_d;
            mv_dn_q      <= mv_dn_d;
        end
    end

    assign bus.mv_up_a     = mv_up_q[0];
    assign bus.mv_dn_a     = mv_dn_q[0];
    assign bus.mv_up_b     = mv_up_q[1];
    assign bus.mv_dn_b     = mv_dn_q[1];
    assign bus.start_pulse = start_q;
    assign bus.btn_lvl     = lvl_q;
endmodule

// File: tb/tb_pong_btn_ctrl.sv
// Bench for pong_btn_ctrl with DEBOUNCE_CYC=4, REPEAT_CYC=8.
// A history-based model derives every output from the raw/reset sample
// history; a compare process checks all outputs each cycle, and directed
// tests pin pulse trains to hand-computed cycle lists.
// Output vector layout used throughout:
//   [0] mv_up_a [1] mv_dn_a [2] mv_up_b [3] mv_dn_b [4] start_pulse
//   [9:5] btn_lvl (bit 5+d is the level of direction/button d)
module tb_pong_btn_ctrl;
    localparam int D = 4;
    localparam int R = 8;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pong_btn_if bus();

    pong_btn_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_CYC(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] raw_h [N];
    logic       rst_h [N];
    logic [4:0] stb_h [N];
    logic [4:0] lvl_h [N];
    logic [9:0] exp_h [N];
    logic [9:0] act_h [N];
    int         run_st [4];
    int         cyc    = 8;   // index of the last processed posedge
    int         n_chk  = 0;
    int         n_err  = 0;
    logic       armed  = 1'b0;

    function automatic logic alone(input logic [4:0] l, input int d);
        return l[d] && !l[d ^ 1];
    endfunction

    // Model + compare: one pass per clock.
    always begin : model
        int   k;
        logic flip, din;
        logic [3:0] pul;
        logic st;
        @(posedge clk);
        k = cyc + 1;
        raw_h[k] = {bus.btn_start, bus.btn_dn_b, bus.btn_up_b, bus.btn_dn_a, bus.btn_up_a};
        rst_h[k] = rst;
        if (rst_h[k]) armed = 1'b1;
        // debounced level: flips once the debouncer has seen D consecutive
        // disagreeing samples (its input lags raw by two edges, reset-free)
        if (rst_h[k]) begin
            stb_h[k] = '0;
            lvl_h[k] = '0;
        end else begin
            lvl_h[k] = stb_h[k-1];
            for (int b = 0; b < 5; b++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    din = (rst_h[k-j-1] || rst_h[k-j-2]) ? 1'b0 : raw_h[k-j-2][b];
                    if (rst_h[k-j] || din == stb_h[k-1][b]) flip = 1'b0;
                end
                stb_h[k][b] = flip ? ~stb_h[k-1][b] : stb_h[k-1][b];
            end
        end
        // paddle pulses: every R cycles from the start of a run of
        // "direction held alone", first one the cycle after the run starts
        for (int d = 0; d < 4; d++) begin
            pul[d] = !rst_h[k] && alone(lvl_h[k-1], d) && (k - 1 >= run_st[d])
                     && (((k - 1 - run_st[d]) % R) == 0);
        end
        for (int d = 0; d < 4; d++) begin
            if (alone(lvl_h[k], d) && !alone(lvl_h[k-1], d))
                run_st[d] = alone(lvl_h[k-1], d ^ 1) ? k + 1 : k;
        end
        st = !rst_h[k] && lvl_h[k-1][4] && !lvl_h[k-2][4];
        exp_h[k] = {lvl_h[k], st, pul};
        cyc = k;
        @(negedge clk);
        act_h[k] = {bus.btn_lvl, bus.start_pulse, bus.mv_dn_b, bus.mv_up_b,
                    bus.mv_dn_a, bus.mv_up_a};
        if (armed) begin
            n_chk++;
            if (act_h[k] !== exp_h[k]) begin
                n_err++;
                $display("FAIL cycle %0d outputs: got %b want %b", k, act_h[k], exp_h[k]);
            end
        end
    end

    task automatic wait_to(input int k);
        while (cyc < k) @(negedge clk);
        #1;
    endtask

    task automatic check_at(input string nm, input int k, input int b, input logic v);
        n_chk++;
        if (act_h[k][b] !== v) begin
            n_err++;
            $display("FAIL %s: cycle %0d bit %0d got %b want %b", nm, k, b, act_h[k][b], v);
        end
    endtask

    // Compare the pulse map of output bit b over [t0, t0+len) to a cycle list.
    task automatic check_train(input string nm, input int b, input int t0,
                               input int len, input int want[$]);
        logic [127:0] got_m, want_m;
        got_m  = '0;
        want_m = '0;
        for (int i = 0; i < len; i++) got_m[i] = act_h[t0+i][b];
        foreach (want[i]) want_m[want[i]] = 1'b1;
        n_chk++;
        if (got_m !== want_m) begin
            n_err++;
            $display("FAIL %s: pulse map got %h want %h", nm, got_m, want_m);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not complete, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0;
        int q[$];
        int none[$];
        for (int i = 0; i < N; i++) begin
            raw_h[i] = '0;
            rst_h[i] = (i <= 8);
            stb_h[i] = '0;
            lvl_h[i] = '0;
            exp_h[i] = '0;
            act_h[i] = '0;
        end
        for (int d = 0; d < 4; d++) run_st[d] = 0;
        bus.btn_up_a  = 1'b0;
        bus.btn_dn_a  = 1'b0;
        bus.btn_up_b  = 1'b0;
        bus.btn_dn_b  = 1'b0;
        bus.btn_start = 1'b0;
        rst = 1'b1;
        wait_to(11);
        rst = 1'b0;
        check_at("reset_lvl", 11, 5, 1'b0);
        check_at("reset_mv",  11, 0, 1'b0);
        wait_to(cyc + 5);

        // 1: up_a held; first low sample lands at cycle 40
        t0 = cyc + 1;
        bus.btn_up_a = 1'b1;
        wait_to(t0 + 39);
        bus.btn_up_a = 1'b0;
        wait_to(t0 + 60);
        q = {7, 15, 23, 31, 39};
        check_train("t1_up_a", 0, t0, 60, q);
        check_train("t1_dn_a", 1, t0, 60, none);
        check_at("t1_lvl_pre",  t0 + 5,  5, 1'b0);
        check_at("t1_lvl_rise", t0 + 6,  5, 1'b1);
        check_at("t1_lvl_hold", t0 + 45, 5, 1'b1);
        check_at("t1_lvl_fall", t0 + 46, 5, 1'b0);

        // 2: 3-cycle glitch on dn_b
        t0 = cyc + 1;
        bus.btn_dn_b = 1'b1;
        wait_to(t0 + 2);
        bus.btn_dn_b = 1'b0;
        wait_to(t0 + 20);
        check_train("t2_dn_b", 3, t0, 20, none);
        check_train("t2_lvl",  8, t0, 20, none);

        // 3: up_a and dn_a together; dn_a first low at cycle 21
        t0 = cyc + 1;
        bus.btn_up_a = 1'b1;
        bus.btn_dn_a = 1'b1;
        wait_to(t0 + 20);
        bus.btn_dn_a = 1'b0;
        wait_to(t0 + 45);
        bus.btn_up_a = 1'b0;
        wait_to(t0 + 70);
        q = {28, 36, 44, 52};
        check_train("t3_up_a", 0, t0, 70, q);
        check_train("t3_dn_a", 1, t0, 70, none);
        check_at("t3_dn_lvl_fall", t0 + 27, 6, 1'b0);

        // 4: start held 60 cycles
        t0 = cyc + 1;
        bus.btn_start = 1'b1;
        wait_to(t0 + 59);
        bus.btn_start = 1'b0;
        wait_to(t0 + 80);
        q = {7};
        check_train("t4_start", 4, t0, 80, q);

        // 5: up_b held, reset sampled at cycle 12
        t0 = cyc + 1;
        bus.btn_up_b = 1'b1;
        wait_to(t0 + 11);
        rst = 1'b1;
        wait_to(t0 + 12);
        rst = 1'b0;
        wait_to(t0 + 40);
        bus.btn_up_b = 1'b0;
        wait_to(t0 + 70);
        q = {7, 20, 28, 36, 44};
        check_train("t5_up_b", 2, t0, 70, q);
        n_chk++;
        if (act_h[t0+12] !== 10'd0) begin
            n_err++;
            $display("FAIL t5_rst_clear: got %b want %b", act_h[t0+12], 10'd0);
        end
        check_at("t5_lvl_pre",  t0 + 18, 7, 1'b0);
        check_at("t5_lvl_rise", t0 + 19, 7, 1'b1);

        // 6: up_a and dn_b concurrently
        t0 = cyc + 1;
        bus.btn_up_a = 1'b1;
        bus.btn_dn_b = 1'b1;
        wait_to(t0 + 30);
        bus.btn_up_a = 1'b0;
        bus.btn_dn_b = 1'b0;
        wait_to(t0 + 50);
        q = {7, 15, 23, 31};
        check_train("t6_up_a", 0, t0, 50, q);
        check_train("t6_dn_b", 3, t0, 50, q);
        check_train("t6_dn_a", 1, t0, 50, none);
        check_train("t6_up_b", 2, t0, 50, none);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
